// File: rtl/music_box_pkg.sv
// Shared definitions for the music box: controller state codes, the song ROM
// entry layout and the sequencer FSM encoding.
package music_box_pkg;

    localparam logic [4:0] STATE_DO_NOTHING     = 5'd0;
    localparam logic [4:0] STATE_PLAY_SONG0     = 5'd1;
    localparam logic [4:0] STATE_PLAY_SONG1     = 5'd2;
    localparam logic [4:0] STATE_PLAY_RECORDING = 5'd3;
    localparam logic [4:0] STATE_MAKE_RECORDING = 5'd4;
    localparam logic [4:0] STATE_DEBUG          = 5'd8;

    localparam int NOTE_W  = 6;
    localparam int BEATS_W = 4;
    localparam int ENTRY_W = NOTE_W + BEATS_W;

    typedef struct packed {
        logic [NOTE_W-1:0]  note;
        logic [BEATS_W-1:0] beats;
    } rom_entry_t;

    // A zero beat count terminates a song.
    localparam logic [BEATS_W-1:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_PLAY,
        SEQ_GAP,
        SEQ_DONE
    } seq_state_t;

    function automatic rom_entry_t make_entry(input int note, input int beats);
        rom_entry_t e;
        e.note  = NOTE_W'(note);
        e.beats = BEATS_W'(beats);
        return e;
    endfunction

endpackage

// File: rtl/music_box_song_rom.sv
// Built-in song ROM: address {song, index}, one registered 10-bit entry per clock.
module music_box_song_rom
    import music_box_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic           clk,
    input  logic [IDX_W:0] addr,
    output rom_entry_t     entry
);

    function automatic rom_entry_t lookup(input logic song, input int unsigned idx);
        rom_entry_t e;
        e = make_entry(0, 0);
        if (!song) begin
            case (idx)
                0:       e = make_entry(5, 1);
                1:       e = make_entry(0, 2);
                2:       e = make_entry(12, 1);
                default: e = make_entry(0, 0);
            endcase
        end else begin
            // Eight one-beat notes, no rest; fills a short song completely.
            case (idx)
                0:       e = make_entry(8, 1);
                1:       e = make_entry(10, 1);
                2:       e = make_entry(12, 1);
                3:       e = make_entry(13, 1);
                4:       e = make_entry(15, 1);
                5:       e = make_entry(17, 1);
                6:       e = make_entry(19, 1);
                7:       e = make_entry(20, 1);
                default: e = make_entry(0, 0);
            endcase
        end
        return e;
    endfunction

    // NOTE: the read register is deliberately left without reset, like a block
    // RAM output; its value is only consumed in FETCH, after a valid address.
    always_ff @(posedge clk) begin
        entry <= lookup(addr[IDX_W], 32'(addr[IDX_W-1:0]));
    end

endmodule

// File: rtl/music_box_song_sequencer.sv
// Steps through the selected song ROM at a fixed tempo while the controller
// requests song 0 or song 1; any other state code aborts playback.
module music_box_song_sequencer
    import music_box_pkg::*;
#(
    parameter  int BEAT_CYCLES = 12_500_000,
    parameter  int GAP_CYCLES  = 1_250_000,
    parameter  int SONG_LEN    = 64,
    localparam int IDX_W       = $clog2(SONG_LEN)
) (
    input  logic              clock_50Mhz,
    input  logic              reset,
    input  logic [4:0]        input_State,
    output logic [NOTE_W-1:0] output_NoteCode,
    output logic              output_NoteValid,
    output logic              output_SongDone,
    output logic              output_Busy,
    output logic [IDX_W-1:0]  output_Index
);

    localparam int                CNT_W    = $clog2(15 * BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  BEAT_CNT = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_CNT  = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SONG_LEN - 1);

    seq_state_t       state_q;
    logic             song_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] play_len;
    logic [4:0]       song_code;
    logic             start;
    logic             leave;
    logic [IDX_W:0]   rom_addr;
    rom_entry_t       rom_q;

    music_box_song_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .clk   (clock_50Mhz),
        .addr  (rom_addr),
        .entry (rom_q)
    );

    assign song_code = song_q ? STATE_PLAY_SONG1 : STATE_PLAY_SONG0;
    assign start     = (input_State == STATE_PLAY_SONG0) || (input_State == STATE_PLAY_SONG1);
    assign leave     = (state_q != SEQ_IDLE) && (input_State != song_code);
    assign play_len  = CNT_W'(rom_q.beats) * BEAT_CNT - GAP_CNT - CNT_W'(1);

    // The address runs one step ahead so the registered ROM word is ready in FETCH.
    // NOTE: rom_addr gets a default before any branch so no latch is inferred.
    always_comb begin
        rom_addr = {song_q, output_Index};
        if (state_q == SEQ_IDLE) begin
            rom_addr = {input_State == STATE_PLAY_SONG1, IDX_W'(0)};
        end else if (state_q == SEQ_GAP && cnt_q == '0) begin
            rom_addr = {song_q, output_Index + IDX_W'(1)};
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state_q          <= SEQ_IDLE;
            song_q           <= 1'b0;
            cnt_q            <= '0;
            output_Index     <= '0;
            output_NoteCode  <= '0;
            output_NoteValid <= 1'b0;
            output_SongDone  <= 1'b0;
            output_Busy      <= 1'b0;
        end else begin
            output_SongDone <= 1'b0;
            if (leave) begin
                // Abort (or release from DONE) wins over any counter expiry.
                state_q          <= SEQ_IDLE;
                output_NoteCode  <= '0;
                output_NoteValid <= 1'b0;
                output_Busy      <= 1'b0;
            end else begin
                case (state_q)
                    SEQ_IDLE: begin
                        if (start) begin
                            song_q       <= (input_State == STATE_PLAY_SONG1);
                            output_Index <= '0;
                            output_Busy  <= 1'b1;
                            state_q      <= SEQ_FETCH;
                        end
                    end
                    SEQ_FETCH: begin
                        if (rom_q.beats == END_MARKER) begin
                            output_SongDone <= 1'b1;
                            state_q         <= SEQ_DONE;
                        end else begin
                            cnt_q            <= play_len;
                            output_NoteCode  <= rom_q.note;
                            output_NoteValid <= (rom_q.note != '0);
                            state_q          <= SEQ_PLAY;
                        end
                    end
                    SEQ_PLAY: begin
                        if (cnt_q == '0) begin
                            cnt_q            <= GAP_CNT - CNT_W'(1);
                            output_NoteCode  <= '0;
                            output_NoteValid <= 1'b0;
                            state_q          <= SEQ_GAP;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    SEQ_GAP: begin
                        if (cnt_q == '0) begin
                            if (output_Index == LAST_IDX) begin
                                output_SongDone <= 1'b1;
                                state_q         <= SEQ_DONE;
                            end else begin
                                output_Index <= output_Index + IDX_W'(1);
                                state_q      <= SEQ_FETCH;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    // DONE is held until the controller leaves the song code.
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_box_song_sequencer.sv
// Scoreboard bench: a timeline model of each song predicts every output cycle,
// a separate monitor compares the DUT against the queued predictions.
module tb_music_box_song_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int SLEN = 8;

    typedef struct packed {
        logic [5:0] note;
        logic       valid;
        logic       done;
        logic       busy;
        logic [2:0] idx;
    } obs_t;

    logic       clock_50Mhz = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] input_State = 5'd0;
    logic [5:0] output_NoteCode;
    logic       output_NoteValid;
    logic       output_SongDone;
    logic       output_Busy;
    logic [2:0] output_Index;

    music_box_song_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .SONG_LEN    (SLEN)
    ) dut (
        .clock_50Mhz      (clock_50Mhz),
        .reset            (reset),
        .input_State      (input_State),
        .output_NoteCode  (output_NoteCode),
        .output_NoteValid (output_NoteValid),
        .output_SongDone  (output_SongDone),
        .output_Busy      (output_Busy),
        .output_Index     (output_Index)
    );

    always #5 clock_50Mhz = ~clock_50Mhz;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Song contents as (note, beats); beats 0 ends the song.
    int song_note  [2][SLEN] = '{'{5, 0, 12, 0, 0, 0, 0, 0}, '{8, 10, 12, 13, 15, 17, 19, 20}};
    int song_beats [2][SLEN] = '{'{1, 2, 1, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1}};

    // Expected output timeline of a full play, one entry per clock from the start edge.
    obs_t trace [2][256];
    int   trace_len [2];

    function automatic void add(input int s, input int note, input bit valid, input bit done, input int idx);
        obs_t e;
        e.note  = 6'(note);
        e.valid = valid;
        e.done  = done;
        e.busy  = 1'b1;
        e.idx   = 3'(idx);
        trace[s][trace_len[s]] = e;
        trace_len[s]++;
    endfunction

    function automatic void build_trace(input int s);
        bit ended = 1'b0;
        trace_len[s] = 0;
        for (int i = 0; i < SLEN; i++) begin
            if (!ended) begin
                add(s, 0, 1'b0, 1'b0, i);
                if (song_beats[s][i] == 0) begin
                    add(s, 0, 1'b0, 1'b1, i);
                    ended = 1'b1;
                end else begin
                    for (int c = 0; c < song_beats[s][i] * BEAT - GAP; c++)
                        add(s, song_note[s][i], song_note[s][i] != 0, 1'b0, i);
                    for (int c = 0; c < GAP; c++)
                        add(s, 0, 1'b0, 1'b0, i);
                end
            end
        end
        if (!ended) add(s, 0, 1'b0, 1'b1, SLEN - 1);
    endfunction

    // Model state: whether a song is playing, which one, and position in its timeline.
    bit         playing = 1'b0;
    int         m_song  = 0;
    int         k       = 0;
    logic [2:0] m_idx   = '0;

    function automatic obs_t model_step(input logic [4:0] st, input logic rst);
        obs_t e;
        e     = '0;
        e.idx = m_idx;
        if (rst) begin
            playing = 1'b0;
            e.idx   = '0;
        end else if (!playing) begin
            if (st == 5'd1 || st == 5'd2) begin
                playing = 1'b1;
                m_song  = (st == 5'd2) ? 1 : 0;
                k       = 0;
                e       = trace[m_song][0];
            end
        end else if (st != 5'(m_song + 1)) begin
            playing = 1'b0;
        end else begin
            k++;
            if (k < trace_len[m_song]) begin
                e = trace[m_song][k];
            end else begin
                e      = trace[m_song][trace_len[m_song] - 1];
                e.done = 1'b0;
            end
        end
        m_idx = e.idx;
        return e;
    endfunction

    obs_t exp_q [$];
    int   tag_q [$];
    int   cyc = 0;

    task automatic drive(input logic [4:0] st, input logic rst);
        input_State = st;
        reset       = rst;
        exp_q.push_back(model_step(st, rst));
        tag_q.push_back(cyc);
        cyc++;
        @(posedge clock_50Mhz);
        #1;
    endtask

    task automatic hold(input logic [4:0] st, input int n);
        for (int i = 0; i < n; i++) drive(st, 1'b0);
    endtask

    task automatic play_to_done(input logic [4:0] st);
        int s;
        s = (st == 5'd2) ? 1 : 0;
        for (int i = 0; i < 400; i++) begin
            if (playing && m_song == s && k == trace_len[s] - 1) break;
            drive(st, 1'b0);
        end
    endtask

    function automatic logic [4:0] pick_code();
        case ($urandom_range(0, 5))
            0:       return 5'd0;
            1, 2:    return 5'd1;
            3:       return 5'd2;
            4:       return 5'd8;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Monitor: one DUT observation per cycle, compared against the oldest prediction.
    initial begin
        obs_t got;
        obs_t e;
        int   tag;
        forever begin
            @(negedge clock_50Mhz);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
                got.note  = output_NoteCode;
                got.valid = output_NoteValid;
                got.done  = output_SongDone;
                got.busy  = output_Busy;
                got.idx   = output_Index;
                check($sformatf("cyc%0d {note,valid,done,busy,idx}", tag), 32'(got), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] st;
        int         n;
        build_trace(0);
        build_trace(1);

        drive(5'd0, 1'b1);
        drive(5'd0, 1'b1);
        hold(5'd0, 3);

        // Full song 0, held past the end, then released and replayed.
        play_to_done(5'd1);
        hold(5'd1, 100);
        hold(5'd0, 3);
        play_to_done(5'd1);
        hold(5'd0, 2);

        // Drop to 0 during the second clock of note 5.
        hold(5'd1, 3);
        hold(5'd0, 4);

        // Song 1 fills the ROM: implicit end, no wrap.
        play_to_done(5'd2);
        hold(5'd2, 5);
        hold(5'd0, 2);

        // Debug code never starts a song and aborts one in progress.
        hold(5'd8, 5);
        hold(5'd1, 15);
        hold(5'd8, 3);
        hold(5'd0, 2);

        // Reset for one cycle while playing, state still 1.
        hold(5'd1, 5);
        drive(5'd1, 1'b1);
        play_to_done(5'd1);
        hold(5'd0, 2);

        // Switch from song 0 to song 1 mid-song.
        hold(5'd1, 12);
        play_to_done(5'd2);
        hold(5'd0, 2);

        // Random state codes with occasional reset.
        for (int seg = 0; seg < 40; seg++) begin
            st = pick_code();
            n  = $urandom_range(1, 60);
            for (int i = 0; i < n; i++) drive(st, $urandom_range(0, 59) == 0);
        end
        hold(5'd0, 2);

        repeat (3) @(posedge clock_50Mhz);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
